exu_mdu_ctrl: RTL and testbench
===============================

// Module: exu_mdu_ctrl
// PURPOSE
//  Sequences the shared iterative multiply/divide unit (MDU) for the EX stage.
//  Accepts a mul/div op from ID/EX, launches the MDU and stalls IF/ID/EX until a result exists.
//  Resolves divide-by-zero and signed overflow itself, without starting the MDU.
//  Handles pipeline flush and MDU timeout, then hands the result to the EX register through a 1-cycle valid.
// PARAMETERS
//  XLEN     64   operand/result width
//  TIMEOUT  80   BUSY cycles without mdu_done before abort (must be > worst MDU latency)
//  CNT_W    7    watchdog counter width; 2^CNT_W > TIMEOUT
// PORTS
//  clk               in   1     clock, rising edge
//  rstn              in   1     asynchronous active-low reset
//  flush_nop         in   1     kill current ID/EX op (branch/jump redirect)
//  idu_mdu_en        in   1     ID/EX holds an M-extension op
//  idu_mdu_opcode    in   3     funct3: 0 mul,1 mulh,2 mulhsu,3 mulhu,4 div,5 divu,6 rem,7 remu
//  idu_mdu_halfop    in   1     *W variant: 32-bit operate, sign-extend result
//  idu_index_rd      in   5     destination register
//  src1, src2        in   XLEN  operands after forwarding mux
//  mdu_start         out  1     1-cycle launch pulse to MDU
//  mdu_op            out  3     latched opcode to MDU
//  mdu_halfop        out  1     latched halfop to MDU
//  mdu_src1,mdu_src2 out  XLEN  latched operands, stable through BUSY
//  mdu_kill          out  1     1-cycle abort pulse to MDU
//  mdu_done          in   1     MDU result valid (1-cycle pulse)
//  mdu_result        in   XLEN  MDU result, valid with mdu_done
//  pipe_stall        out  1     hold PC, IF/ID, ID/EX; EX register bubbles
//  mdu_wb_valid      out  1     result valid this cycle; EX mux selects mdu_wb_data
//  mdu_wb_data       out  XLEN  final result
//  mdu_wb_rd         out  5     destination of mdu_wb_data
//  mdu_err           out  1     sticky: a timeout occurred
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, cnt=0; every output 0 incl. mdu_err, mdu_src*, mdu_wb_data.
//  accept = state==IDLE & idu_mdu_en & !flush_nop.
//  pipe_stall = accept | state==BUSY (combinational). It is low in DONE, so the held op advances into EX.
//  IDLE:
//   - On accept, latch op/halfop/src1/src2/rd.
//   - special case (div/rem with divisor==0, or signed div/rem with dividend==MIN and divisor==-1;
//     halfop tests the low 32 bits only): compute the result, -> DONE.
//   - Otherwise -> BUSY with cnt=0.
//   - mdu_done is ignored in IDLE.
//  Special results:
//   - divisor 0: div/divu = all ones; rem/remu = dividend.
//   - overflow: div = dividend; rem = 0.
//   - halfop results are sext(res[31:0]).
//  BUSY:
//   - mdu_start=1 in the first BUSY cycle only; cnt increments each cycle.
//   - mdu_done: latch mdu_result (sext low 32 if halfop), -> DONE.
//   - flush_nop (priority over a simultaneous mdu_done): mdu_kill=1 next cycle, result discarded, -> IDLE.
//   - cnt==TIMEOUT-1 without done: mdu_kill=1, mdu_err<=1, result=0, -> DONE.
//  DONE: mdu_wb_valid=1 for exactly 1 cycle with data/rd, then -> IDLE. A new accept is possible the following cycle.
//  Latency:
//   - special case: stall 1 cycle, valid the next cycle.
//   - normal: stall = 1 + MDU latency + 1; mdu_wb_valid the cycle after mdu_done.
//  mdu_start and mdu_kill are never high in the same cycle.
//  mdu_src* change only on accept.
//  Reset mid-BUSY returns to IDLE with no kill pulse; the MDU has the same reset.
// TESTING
//  1. div, src1=100, src2=7; MDU done 34 cycles after start
//     -> stall 36 cycles, then mdu_wb_valid=1, data=14, mdu_start pulsed once.
//  2. divu, src2=0, src1=5 -> no mdu_start; stall 1 cycle; data=64'hFFFF_FFFF_FFFF_FFFF.
//     remu, src2=0 -> data=5.
//  3. divw, src1=32'h8000_0000, src2=-1 -> no start; data=64'hFFFF_FFFF_8000_0000.
//     remw with the same operands -> data=0.
//  4. mul started, flush_nop in the same cycle as mdu_done
//     -> mdu_kill pulse, no mdu_wb_valid, stall drops, back to IDLE.
//  5. MDU never responds -> mdu_kill at BUSY cycle TIMEOUT; mdu_err=1 and stays 1;
//     mdu_wb_valid with data=0.
//  6. Back-to-back mul then mulhu; async reset asserted mid-BUSY
//     -> all outputs 0 at once, next op accepted normally.

Source files
------------

// File: rtl/exu_mdu_ctrl.sv
// EX-stage sequencer for the shared iterative multiply/divide unit.
// Launches the MDU, stalls the pipe, resolves trivial divides locally and hands back one result.
module exu_mdu_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_nop,
  input  logic            idu_mdu_en,
  input  logic [2:0]      idu_mdu_opcode,
  input  logic            idu_mdu_halfop,
  input  logic [4:0]      idu_index_rd,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            mdu_start,
  output logic [2:0]      mdu_op,
  output logic            mdu_halfop,
  output logic [XLEN-1:0] mdu_src1,
  output logic [XLEN-1:0] mdu_src2,
  output logic            mdu_kill,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            pipe_stall,
  output logic            mdu_wb_valid,
  output logic [XLEN-1:0] mdu_wb_data,
  output logic [4:0]      mdu_wb_rd,
  output logic            mdu_err
);

  // state  | meaning
  // S_IDLE | waiting for an op from ID/EX
  // S_BUSY | MDU running, watchdog counting
  // S_DONE | result presented to EX for one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_halfop;
  logic [XLEN-1:0]   r_src1;
  logic [XLEN-1:0]   r_src2;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd;
  logic              r_err;
  logic              r_kill_flush;

  logic              w_accept;
  logic              w_busy;
  logic              w_timeout;
  logic              w_is_div;
  logic              w_signed_op;
  logic              w_is_rem;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_raw;
  logic [XLEN-1:0]   w_spec_result;
  logic [XLEN-1:0]   w_mdu_res;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  assign w_busy    = (r_state == S_BUSY);
  assign w_accept  = (r_state == S_IDLE) & idu_mdu_en & ~flush_nop;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Divide-by-zero and signed overflow are answered here without the MDU.
  always_comb begin
    w_is_div    = idu_mdu_opcode[2];
    w_signed_op = ~idu_mdu_opcode[0];
    w_is_rem    = idu_mdu_opcode[1];
    if (idu_mdu_halfop) begin
      w_div_zero = (src2[31:0] == 32'h0);
      w_ovf      = w_signed_op & (src1[31:0] == 32'h8000_0000) & (src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_div_zero = (src2 == '0);
      w_ovf      = w_signed_op & (src1 == MIN_X) & (src2 == '1);
    end
    w_special = w_is_div & (w_div_zero | w_ovf);
    if (w_div_zero) begin
      w_spec_raw = w_is_rem ? src1 : '1;
    end else begin
      w_spec_raw = w_is_rem ? '0 : src1;
    end
    w_spec_result = idu_mdu_halfop ? sext32(w_spec_raw) : w_spec_raw;
    w_mdu_res     = r_halfop ? sext32(mdu_result) : mdu_result;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (flush_nop)      w_state_nxt = S_IDLE;
        else if (mdu_done)  w_state_nxt = S_DONE;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt        <= '0;
      r_op         <= '0;
      r_halfop     <= 1'b0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_result     <= '0;
      r_rd         <= '0;
      r_err        <= 1'b0;
      r_kill_flush <= 1'b0;
    end else begin
      r_kill_flush <= w_busy & flush_nop;
      if (w_accept) begin
        r_op     <= idu_mdu_opcode;
        r_halfop <= idu_mdu_halfop;
        r_src1   <= src1;
        r_src2   <= src2;
        r_rd     <= idu_index_rd;
        r_cnt    <= '0;
        if (w_special) r_result <= w_spec_result;
      end
      if (w_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // A flush discards whatever the MDU returns in the same cycle.
        if (!flush_nop) begin
          if (mdu_done) begin
            r_result <= w_mdu_res;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
      end
    end
  end

  assign pipe_stall   = w_accept | w_busy;
  assign mdu_start    = w_busy & (r_cnt == '0);
  assign mdu_kill     = r_kill_flush | (w_busy & ~flush_nop & ~mdu_done & w_timeout);
  assign mdu_op       = r_op;
  assign mdu_halfop   = r_halfop;
  assign mdu_src1     = r_src1;
  assign mdu_src2     = r_src2;
  assign mdu_wb_valid = (r_state == S_DONE);
  assign mdu_wb_data  = r_result;
  assign mdu_wb_rd    = r_rd;
  assign mdu_err      = r_err;

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// Randomized bench for exu_mdu_ctrl: an op-level reference model sets the expected outputs
// of each cycle, and one compare process checks them on every falling edge.
module tb_exu_mdu_ctrl;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 80;
  localparam int CNT_W   = 7;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush_nop;
  logic        idu_mdu_en;
  logic [2:0]  idu_mdu_opcode;
  logic        idu_mdu_halfop;
  logic [4:0]  idu_index_rd;
  logic [63:0] src1, src2;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic        mdu_halfop;
  logic [63:0] mdu_src1, mdu_src2;
  logic        mdu_kill;
  logic        mdu_done;
  logic [63:0] mdu_result;
  logic        pipe_stall;
  logic        mdu_wb_valid;
  logic [63:0] mdu_wb_data;
  logic [4:0]  mdu_wb_rd;
  logic        mdu_err;

  exu_mdu_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush_nop(flush_nop), .idu_mdu_en(idu_mdu_en),
    .idu_mdu_opcode(idu_mdu_opcode), .idu_mdu_halfop(idu_mdu_halfop), .idu_index_rd(idu_index_rd),
    .src1(src1), .src2(src2), .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_halfop(mdu_halfop),
    .mdu_src1(mdu_src1), .mdu_src2(mdu_src2), .mdu_kill(mdu_kill), .mdu_done(mdu_done),
    .mdu_result(mdu_result), .pipe_stall(pipe_stall), .mdu_wb_valid(mdu_wb_valid),
    .mdu_wb_data(mdu_wb_data), .mdu_wb_rd(mdu_wb_rd), .mdu_err(mdu_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  bit          chk_on   = 1'b0;
  logic        exp_stall, exp_start, exp_kill, exp_valid, exp_err, exp_half;
  logic [63:0] exp_data, exp_src1, exp_src2;
  logic [2:0]  exp_op;
  logic [4:0]  exp_rd;
  int          stall_cnt, start_cnt, kill_cnt, valid_cnt;
  logic [63:0] last_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic half,
                                    input logic [63:0] a, input logic [63:0] b);
    bit dz, ov;
    if (half) begin
      dz = (b[31:0] == 32'h0);
      ov = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    end else begin
      dz = (b == 64'h0);
      ov = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    return op[2] && (dz || (!op[0] && ov));
  endfunction

  // RISC-V M-extension result of an op, including the divide corner cases.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic half,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32, r32;
    logic [63:0]         r;
    bit                  ov64, ov32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    ov64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ov32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    r = '0; r32 = '0;
    if (half) begin
      case (op)
        3'd4: if (b32 == 0) r32 = '1; else if (ov32) r32 = a32; else r32 = sa32 / sb32;
        3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        3'd6: if (b32 == 0) r32 = a32; else if (ov32) r32 = '0; else r32 = sa32 % sb32;
        3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        3'd0: r = a * b;
        3'd1: begin pa = sa; pb = sb; ps = pa * pb; r = ps[127:64]; end
        3'd2: begin pa = sa; pb = $signed({64'd0, b}); ps = pa * pb; r = ps[127:64]; end
        3'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
        3'd4: if (b == 0) r = '1; else if (ov64) r = a; else r = sa / sb;
        3'd5: if (b == 0) r = '1; else r = a / b;
        3'd6: if (b == 0) r = a; else if (ov64) r = '0; else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("pipe_stall", 64'(pipe_stall), 64'(exp_stall));
      check("mdu_start", 64'(mdu_start), 64'(exp_start));
      check("mdu_kill", 64'(mdu_kill), 64'(exp_kill));
      check("start_kill_excl", 64'(mdu_start & mdu_kill), 64'd0);
      check("mdu_wb_valid", 64'(mdu_wb_valid), 64'(exp_valid));
      check("mdu_err", 64'(mdu_err), 64'(exp_err));
      check("mdu_src1", mdu_src1, exp_src1);
      check("mdu_src2", mdu_src2, exp_src2);
      check("mdu_op", 64'(mdu_op), 64'(exp_op));
      check("mdu_halfop", 64'(mdu_halfop), 64'(exp_half));
      if (exp_valid) begin
        check("mdu_wb_data", mdu_wb_data, exp_data);
        check("mdu_wb_rd", 64'(mdu_wb_rd), 64'(exp_rd));
      end
    end
    if (pipe_stall)   stall_cnt++;
    if (mdu_start)    start_cnt++;
    if (mdu_kill)     kill_cnt++;
    if (mdu_wb_valid) begin valid_cnt++; last_data = mdu_wb_data; end
  end

  task automatic clr_cnt();
    stall_cnt = 0; start_cnt = 0; kill_cnt = 0; valid_cnt = 0; last_data = 64'hDEAD_BEEF;
  endtask

  // Advance to just after the next rising edge with quiet default inputs/expectations.
  task automatic cyc();
    @(posedge clk);
    #1;
    exp_start = 1'b0; exp_kill = 1'b0; exp_valid = 1'b0; exp_stall = 1'b0;
    flush_nop = 1'b0; mdu_done = 1'b0; mdu_result = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      idu_mdu_en = 1'($urandom_range(0, 1));
      flush_nop  = idu_mdu_en ? 1'b1 : 1'($urandom_range(0, 1));
      mdu_done   = 1'($urandom_range(0, 1));
      idu_mdu_opcode = 3'($urandom_range(0, 7));
      src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    end
  endtask

  // lat: cycles from mdu_start to mdu_done (-1: never). flush_at: BUSY cycle carrying flush (0: none).
  task automatic run_op(input logic [2:0] op, input logic half, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b, input int lat, input int flush_at);
    logic [63:0] r;
    bit          sp;
    int          k;
    r  = ref_result(op, half, a, b);
    sp = is_special(op, half, a, b);
    cyc();
    idu_mdu_en = 1'b1; idu_mdu_opcode = op; idu_mdu_halfop = half; idu_index_rd = rd;
    src1 = a; src2 = b; exp_stall = 1'b1;
    cyc();
    exp_src1 = a; exp_src2 = b; exp_op = op; exp_half = half;
    if (sp) begin
      exp_valid = 1'b1; exp_data = r; exp_rd = rd;
    end else begin
      k = 1;
      forever begin
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        exp_stall = 1'b1; exp_start = (k == 1);
        if (k == flush_at) begin
          flush_nop = 1'b1;
          if (k == lat + 1) mdu_done = 1'b1;
          cyc();
          idu_mdu_en = 1'b0; exp_kill = 1'b1;
          break;
        end
        if (k == lat + 1) begin
          mdu_done = 1'b1;
          mdu_result = half ? {$urandom, r[31:0]} : r;
          cyc();
          exp_valid = 1'b1; exp_data = r; exp_rd = rd;
          break;
        end
        if (k == TIMEOUT) begin
          exp_kill = 1'b1;
          cyc();
          exp_err = 1'b1; exp_valid = 1'b1; exp_data = 64'd0; exp_rd = rd;
          break;
        end
        cyc();
        k++;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic rand_op();
    logic [2:0]  op;
    logic        half;
    logic [63:0] a, b;
    int          sel, lat, fl;
    op   = 3'($urandom_range(0, 7));
    half = (op == 3'd0 || op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sel = $urandom_range(0, 7);
    if (sel < 2) b = half ? {$urandom, 32'h0} : 64'd0;
    else if (sel == 2) begin
      a = half ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
      b = half ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    lat = $urandom_range(0, 40);
    fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + 1) : 0;
    run_op(op, half, 5'($urandom_range(0, 31)), a, b, lat, fl);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1; flush_nop = 1'b0; idu_mdu_en = 1'b0; idu_mdu_opcode = '0; idu_mdu_halfop = 1'b0;
    idu_index_rd = '0; src1 = '0; src2 = '0; mdu_done = 1'b0; mdu_result = '0;
    exp_stall = 0; exp_start = 0; exp_kill = 0; exp_valid = 0; exp_err = 0; exp_half = 0;
    exp_data = '0; exp_src1 = '0; exp_src2 = '0; exp_op = '0; exp_rd = '0;
    clr_cnt();
    #1 rstn = 1'b0;
    #1 chk_on = 1'b1;
    #10;
    check("rst_wb_data", mdu_wb_data, 64'd0);
    check("rst_wb_rd", 64'(mdu_wb_rd), 64'd0);
    check("rst_wb_valid", 64'(mdu_wb_valid), 64'd0);
    #10 rstn = 1'b1;

    // model pins
    check("model_div", ref_result(3'd4, 1'b0, 64'd100, 64'd7), 64'd14);
    check("model_divw_ovf", ref_result(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF),
          64'hFFFF_FFFF_8000_0000);

    clr_cnt();
    run_op(3'd4, 1'b0, 5'd10, 64'd100, 64'd7, 34, 0);
    check("t1_stall_cycles", 64'(stall_cnt), 64'd36);
    check("t1_start_pulses", 64'(start_cnt), 64'd1);
    check("t1_data", last_data, 64'd14);

    clr_cnt();
    run_op(3'd5, 1'b0, 5'd3, 64'd5, 64'd0, 0, 0);
    check("t2_stall_cycles", 64'(stall_cnt), 64'd1);
    check("t2_divu0_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd7, 1'b0, 5'd4, 64'd5, 64'd0, 0, 0);
    check("t2_remu0_data", last_data, 64'd5);
    check("t2_no_start", 64'(start_cnt), 64'd0);

    clr_cnt();
    run_op(3'd4, 1'b1, 5'd5, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("t3_divw_data", last_data, 64'hFFFF_FFFF_8000_0000);
    run_op(3'd6, 1'b1, 5'd6, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("t3_remw_data", last_data, 64'd0);
    check("t3_no_start", 64'(start_cnt), 64'd0);

    clr_cnt();
    run_op(3'd0, 1'b0, 5'd7, 64'd12345, 64'd678, 10, 11);
    check("t4_kill_pulses", 64'(kill_cnt), 64'd1);
    check("t4_no_valid", 64'(valid_cnt), 64'd0);
    check("t4_stall_low", 64'(pipe_stall), 64'd0);

    repeat (40) rand_op();

    clr_cnt();
    run_op(3'd3, 1'b0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, TIMEOUT - 1, 0);
    check("late_done_no_kill", 64'(kill_cnt), 64'd0);
    check("late_done_data", last_data, 64'd2);

    clr_cnt();
    run_op(3'd0, 1'b0, 5'd9, 64'd3, 64'd4, -1, 0);
    check("t5_kill_pulses", 64'(kill_cnt), 64'd1);
    check("t5_stall_cycles", 64'(stall_cnt), 64'(1 + TIMEOUT));
    check("t5_data", last_data, 64'd0);
    check("t5_err", 64'(mdu_err), 64'd1);
    idle(3);
    run_op(3'd1, 1'b0, 5'd11, 64'd7, 64'd9, 5, 0);
    check("t5_err_sticky", 64'(mdu_err), 64'd1);

    // reset in the middle of a busy mulhu
    clr_cnt();
    cyc();
    idu_mdu_en = 1'b1; idu_mdu_opcode = 3'd3; idu_mdu_halfop = 1'b0; idu_index_rd = 5'd12;
    src1 = 64'hAAAA_0000_1111_2222; src2 = 64'h1234; exp_stall = 1'b1;
    cyc();
    exp_src1 = 64'hAAAA_0000_1111_2222; exp_src2 = 64'h1234; exp_op = 3'd3; exp_half = 1'b0;
    exp_stall = 1'b1; exp_start = 1'b1;
    cyc();
    exp_stall = 1'b1;
    #2;
    rstn = 1'b0; idu_mdu_en = 1'b0;
    exp_stall = 0; exp_start = 0; exp_kill = 0; exp_valid = 0; exp_err = 0;
    exp_src1 = '0; exp_src2 = '0; exp_op = '0; exp_half = 1'b0;
    #1;
    check("t6_rst_stall", 64'(pipe_stall), 64'd0);
    check("t6_rst_err", 64'(mdu_err), 64'd0);
    check("t6_rst_src1", mdu_src1, 64'd0);
    check("t6_rst_wb_data", mdu_wb_data, 64'd0);
    check("t6_rst_wb_rd", 64'(mdu_wb_rd), 64'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    check("t6_no_kill", 64'(kill_cnt), 64'd0);
    run_op(3'd0, 1'b0, 5'd13, 64'd6, 64'd7, 3, 0);
    check("t6_mul_data", last_data, 64'd42);
    run_op(3'd3, 1'b0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0);
    check("t6_mulhu_data", last_data, 64'hFFFF_FFFF_FFFF_FFFE);

    repeat (20) rand_op();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
